// File: rtl/seq_mult_ctrl.sv
// Self-controlled shift-and-add multiplier with valid/ready handshakes and a
// runtime signed/unsigned mode; control FSM, iteration counter and datapath in one block.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     op_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH:0]   sum;

    // The magnitude of the most-negative operand still fits as an unsigned WIDTH-bit value.
    assign b_mag = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;
    assign q_mag = (signed_mode && op_q[WIDTH-1]) ? -op_q : op_q;

    // The carry out of the add becomes the new A[MSB] in the same cycle's shift.
    assign sum = q_reg[0] ? ({1'b0, a_reg} + {1'b0, b_reg}) : {1'b0, a_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg <= b_mag;
                        q_reg <= q_mag;
                        a_reg <= '0;
                        cnt   <= CW'(WIDTH);
                        neg   <= signed_mode & (op_b[WIDTH-1] ^ op_q[WIDTH-1]);
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= sum[WIDTH:1];
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    product <= neg ? -{a_reg, q_reg} : {a_reg, q_reg};
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == ADJ);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomised checks of seq_mult_ctrl at WIDTH = 8, 2, 5 and 16,
// with handshake, back-pressure and mid-operation reset scenarios.
module tb_seq_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        signed_mode;
    logic        out_ready;
    logic [31:0] op_b;
    logic [31:0] op_q;
    int          cur;
    int          checks;
    int          errors;

    logic        ir8, ov8, bs8;
    logic        ir2, ov2, bs2;
    logic        ir5, ov5, bs5;
    logic        ir16, ov16, bs16;
    logic [15:0] p8;
    logic [3:0]  p2;
    logic [9:0]  p5;
    logic [31:0] p16;

    logic        c_in_ready;
    logic        c_out_valid;
    logic        c_busy;
    logic [63:0] c_product;

    seq_mult_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && cur == 0), .in_ready(ir8),
        .signed_mode(signed_mode), .op_b(op_b[7:0]), .op_q(op_q[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .product(p8), .busy(bs8)
    );

    seq_mult_ctrl #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && cur == 1), .in_ready(ir2),
        .signed_mode(signed_mode), .op_b(op_b[1:0]), .op_q(op_q[1:0]),
        .out_valid(ov2), .out_ready(out_ready), .product(p2), .busy(bs2)
    );

    seq_mult_ctrl #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && cur == 2), .in_ready(ir5),
        .signed_mode(signed_mode), .op_b(op_b[4:0]), .op_q(op_q[4:0]),
        .out_valid(ov5), .out_ready(out_ready), .product(p5), .busy(bs5)
    );

    seq_mult_ctrl #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && cur == 3), .in_ready(ir16),
        .signed_mode(signed_mode), .op_b(op_b[15:0]), .op_q(op_q[15:0]),
        .out_valid(ov16), .out_ready(out_ready), .product(p16), .busy(bs16)
    );

    always_comb begin
        c_in_ready  = ir8;
        c_out_valid = ov8;
        c_busy      = bs8;
        c_product   = 64'(p8);
        case (cur)
            1: begin c_in_ready = ir2;  c_out_valid = ov2;  c_busy = bs2;  c_product = 64'(p2);  end
            2: begin c_in_ready = ir5;  c_out_valid = ov5;  c_busy = bs5;  c_product = 64'(p5);  end
            3: begin c_in_ready = ir16; c_out_valid = ov16; c_busy = bs16; c_product = 64'(p16); end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: sign-extend (or zero-extend) to 64 bits, multiply, keep 2*w bits.
    function automatic logic [63:0] model(input int w, input bit sm, input logic [31:0] b, input logic [31:0] q);
        logic [31:0] m;
        longint sb, sq, p;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sb = longint'(b & m);
        sq = longint'(q & m);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        if (sm && q[w-1]) sq = sq - (longint'(1) << w);
        p = sb * sq;
        if (2 * w < 64) p = p & ((longint'(1) << (2 * w)) - 1);
        return 64'(p);
    endfunction

    // Presents one operand pair in IDLE and waits for out_valid; lat counts the accepting edge as 1.
    task automatic applyStimulus(input bit sm, input logic [31:0] b, input logic [31:0] q,
                                 output logic [63:0] prod, output int lat);
        signed_mode = sm;
        op_b        = b;
        op_q        = q;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        lat         = 1;
        in_valid    = 1'b0;
        op_b        = ~b;
        op_q        = ~q;
        signed_mode = ~sm;
        while (!c_out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = c_product;
    endtask

    task automatic runOne(input string tag, input bit sm, input logic [31:0] b, input logic [31:0] q,
                          input logic [63:0] expected, input int expLat);
        logic [63:0] prod;
        int          lat;
        applyStimulus(sm, b, q, prod, lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput(tag, prod, expected);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] prod;
        int          lat;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] m;
        int          w;
        bit          sm;

        checks      = 0;
        errors      = 0;
        cur         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        op_b        = '0;
        op_q        = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset in_ready", 64'(c_in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(c_out_valid), 64'd0);
        checkOutput("reset busy", 64'(c_busy), 64'd0);
        checkOutput("reset product", c_product, 64'd0);

        runOne("u 255x255", 1'b0, 32'd255, 32'd255, 64'hFE01, 10);
        runOne("u 13x11", 1'b0, 32'd13, 32'd11, 64'd143, 10);
        runOne("u 128x128", 1'b0, 32'h80, 32'h80, 64'h4000, 10);
        runOne("s -128x-128", 1'b1, 32'h80, 32'h80, 64'h4000, 10);
        runOne("s -3x7", 1'b1, 32'hFD, 32'h07, 64'hFFEB, 10);
        runOne("s 0x-5", 1'b1, 32'h00, 32'hFB, 64'h0000, 10);
        runOne("s 127x-1", 1'b1, 32'h7F, 32'hFF, 64'hFF81, 10);
        runOne("u 253x7", 1'b0, 32'hFD, 32'h07, 64'h06EB, 10);

        // Back-pressure: DONE must hold its product and refuse new operands.
        applyStimulus(1'b0, 32'd200, 32'd3, prod, lat);
        checkOutput("bp product", prod, 64'd600);
        for (int i = 0; i < 20; i++) begin
            in_valid    = i[0];
            op_b        = $urandom;
            op_q        = $urandom;
            signed_mode = i[1];
            @(posedge clk);
            #1;
            checkOutput("bp hold product", c_product, 64'd600);
            checkOutput("bp in_ready", 64'(c_in_ready), 64'd0);
            checkOutput("bp out_valid", 64'(c_out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp release in_ready", 64'(c_in_ready), 64'd1);
        checkOutput("bp release out_valid", 64'(c_out_valid), 64'd0);
        checkOutput("bp release busy", 64'(c_busy), 64'd0);
        checkOutput("bp idle product", c_product, 64'd600);

        // Mid-operation reset during the fourth CALC cycle.
        signed_mode = 1'b0;
        op_b        = 32'd9;
        op_q        = 32'd9;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("calc busy", 64'(c_busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", 64'(c_in_ready), 64'd1);
        checkOutput("abort busy", 64'(c_busy), 64'd0);
        checkOutput("abort out_valid", 64'(c_out_valid), 64'd0);
        checkOutput("abort product", c_product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        runOne("u 6x7 after reset", 1'b0, 32'd6, 32'd7, 64'd42, 10);

        // Randomised sweep on the other widths, both modes.
        for (int k = 1; k <= 3; k++) begin
            cur = k;
            w   = (k == 1) ? 2 : (k == 2) ? 5 : 16;
            m   = (32'd1 << w) - 32'd1;
            for (int i = 0; i < 400; i++) begin
                sm = i[0];
                b  = $urandom & m;
                q  = $urandom & m;
                if (i < 2) begin
                    b = 32'd1 << (w - 1);
                    q = 32'd1 << (w - 1);
                end
                runOne($sformatf("w%0d sm%0d %0h*%0h", w, sm, b, q), sm, b, q, model(w, sm, b, q), w + 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Parametrised, self-controlled shift-and-add sequential multiplier: control FSM, counter and datapath merged into one block.
- Adds three things the 5-bit datapath-only generation lacks: a valid/ready handshake on operands and product, a runtime signed/unsigned mode, and a single-cycle combined add+shift per iteration.
- Sits between an operand producer and a result consumer in the arithmetic pipeline.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands (high only in IDLE)
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled with operands
- op_b  input  WIDTH  multiplicand
- op_q  input  WIDTH  multiplier
- out_valid  output  1  product valid (high only in DONE)
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  result, held stable while out_valid=1
- busy  output  1  high in CALC or ADJ

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers=0. Reset mid-operation aborts the multiply with no output. The first edge after release operates normally.
- States: IDLE, CALC, ADJ, DONE.
- IDLE, on in_valid & in_ready at an edge:
  - B <= |op_b|, Q <= |op_q|, A <= 0, C <= 0, cnt <= WIDTH, neg <= signed_mode & (op_b[MSB] ^ op_q[MSB]).
  - Magnitude is taken only when signed_mode=1; otherwise operands pass through.
  - Next state is CALC.
- CALC: one iteration per cycle.
  - {C,A} sum = Q[0] ? A+B : {1'b0,A}.
  - Then {C,A,Q} <= {sum,Q} >> 1 with C <= 0, all at the same edge.
  - cnt decrements. When cnt reaches 1 at an edge, next state is ADJ (exactly WIDTH CALC cycles).
- ADJ: product <= neg ? -{A,Q} : {A,Q}, truncated to 2*WIDTH bits. Next state is DONE.
- DONE: out_valid=1, product stable.
  - On out_ready=1 at an edge, go to IDLE and drop out_valid.
  - Back-pressure holds DONE indefinitely.
- Latency: out_valid rises WIDTH+2 edges after the accepting edge (WIDTH=8: 10 cycles). Throughput is one product per WIDTH+3 cycles with out_ready tied high.
- No operand acceptance outside IDLE. in_valid in other states is ignored, and operands are not captured.
- Signed edge cases:
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits, so the magnitude is exact.
  - The most-negative squared result, +2^(2*WIDTH-2), fits in 2*WIDTH signed bits.
  - A zero product with neg=1 yields 0, since negating 0 gives 0.
- Unsigned: the full 2*WIDTH-bit result never overflows. The carry C feeds A[MSB] on shift.
- Counter width: $clog2(WIDTH+1). cnt never wraps, because the exit condition is checked at cnt==1.
- Outputs are registered except in_ready, out_valid and busy, which are decoded directly from the state register.

Test Plan:
- Reset/idle: hold rst_n=0 three cycles, release. Required: in_ready=1, out_valid=0, busy=0, product=0.
- Unsigned, WIDTH=8: signed_mode=0, op_b=255, op_q=255. Required: product=65025 (0xFE01), out_valid exactly 10 cycles after acceptance. 13×11 must give 143.
- Signed, WIDTH=8, signed_mode=1:
  - -128×-128 = 16384 (0x4000)
  - -3×7 = -21 (0xFFEB)
  - 0×-5 = 0
  - 127×-1 = -127 (0xFF81)
- Back-pressure: hold out_ready=0 for 20 cycles in DONE, pulsing in_valid throughout. Required: product stable, in_ready=0, no capture. After out_ready=1, IDLE follows at the next edge.
- Mid-operation reset: assert rst_n=0 asynchronously at CALC cycle 4. Required: immediate IDLE with product=0. A subsequent 6×7 unsigned gives 42.
- Parameter sweep: WIDTH=2, 5 and 16, each with 200 random operands in both modes against a reference model. Required: every product matches, and latency equals WIDTH+2 edges.
